// File: rtl/rb_operand_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : rb_operand_fetch_if
//  Purpose  : Request, execute, writeback and register-bank signal bundle
//  Revision : 1.0
// ============================================================================
interface rb_operand_fetch_if #(
    parameter int LANES  = 16,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6,
    parameter int TAG_W  = 8
);
    logic                      req_valid;
    logic                      req_ready;
    logic [ADDR_W-1:0]         req_rs1;
    logic [ADDR_W-1:0]         req_rs2;
    logic                      req_use1;
    logic                      req_use2;
    logic [ADDR_W-1:0]         req_rd;
    logic                      req_wr;
    logic [LANES-1:0]          req_mask;
    logic [TAG_W-1:0]          req_tag;

    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*DATA_W-1:0]   out_op1;
    logic [LANES*DATA_W-1:0]   out_op2;
    logic [LANES-1:0]          out_mask;
    logic [TAG_W-1:0]          out_tag;

    logic                      wb_valid;
    logic [ADDR_W-1:0]         wb_addr;
    logic [LANES-1:0]          wb_mask;
    logic [LANES*DATA_W-1:0]   wb_data;
    logic                      wb_last;

    logic [LANES-1:0]          read_en_0;
    logic [LANES-1:0]          read_en_1;
    logic [ADDR_W-1:0]         raddr_0;
    logic [ADDR_W-1:0]         raddr_1;
    logic [LANES*DATA_W-1:0]   rdata_0;
    logic [LANES*DATA_W-1:0]   rdata_1;
    logic [LANES-1:0]          write_en;
    logic [ADDR_W-1:0]         waddr;
    logic [LANES*DATA_W-1:0]   wdata;

    // Controller view
    modport slave (
        input  req_valid, req_rs1, req_rs2, req_use1, req_use2, req_rd, req_wr,
               req_mask, req_tag, out_ready, wb_valid, wb_addr, wb_mask, wb_data,
               wb_last, rdata_0, rdata_1,
        output req_ready, out_valid, out_op1, out_op2, out_mask, out_tag,
               read_en_0, read_en_1, raddr_0, raddr_1, write_en, waddr, wdata
    );

    // Pipeline / bank view
    modport master (
        output req_valid, req_rs1, req_rs2, req_use1, req_use2, req_rd, req_wr,
               req_mask, req_tag, out_ready, wb_valid, wb_addr, wb_mask, wb_data,
               wb_last, rdata_0, rdata_1,
        input  req_ready, out_valid, out_op1, out_op2, out_mask, out_tag,
               read_en_0, read_en_1, raddr_0, raddr_1, write_en, waddr, wdata
    );
endinterface
`default_nettype wire

// File: rtl/rb_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : rb_operand_fetch
//  Purpose  : Register-bank operand fetch with pending scoreboard and bypass
//  Revision : 1.0
// ============================================================================
module rb_operand_fetch #(
    parameter int LANES  = 16,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6,
    parameter int TAG_W  = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rb_operand_fetch_if.slave  bus
);
    localparam int NREG = 2**ADDR_W;
    localparam int LW   = LANES*DATA_W;

    logic [NREG-1:0]  r_pending;
    logic [NREG-1:0]  w_pending_nxt;
    logic             r_out_valid;
    logic [LW-1:0]    r_out_op1;
    logic [LW-1:0]    r_out_op2;
    logic [LANES-1:0] r_out_mask;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_wb_clr;
    logic             w_hz1;
    logic             w_hz2;
    logic             w_ready;
    logic             w_accept;
    logic             w_byp1_addr;
    logic             w_byp2_addr;
    logic [LW-1:0]    w_op1;
    logic [LW-1:0]    w_op2;

    assign w_wb_clr = bus.wb_valid && bus.wb_last;

    // A final writeback landing this cycle resolves the hazard it would otherwise cause
    assign w_hz1 = bus.req_use1 && r_pending[bus.req_rs1] &&
                   !(w_wb_clr && (bus.wb_addr == bus.req_rs1));
    assign w_hz2 = bus.req_use2 && r_pending[bus.req_rs2] &&
                   !(w_wb_clr && (bus.wb_addr == bus.req_rs2));

    assign w_ready  = !(w_hz1 || w_hz2) && (!r_out_valid || bus.out_ready);
    assign w_accept = bus.req_valid && w_ready;

    assign bus.req_ready = w_ready;
    assign bus.raddr_0   = bus.req_rs1;
    assign bus.raddr_1   = bus.req_rs2;
    assign bus.read_en_0 = (bus.req_valid && bus.req_use1) ? bus.req_mask : '0;
    assign bus.read_en_1 = (bus.req_valid && bus.req_use2) ? bus.req_mask : '0;
    assign bus.write_en  = bus.wb_valid ? bus.wb_mask : '0;
    assign bus.waddr     = bus.wb_addr;
    assign bus.wdata     = bus.wb_data;

    assign w_byp1_addr = bus.wb_valid && (bus.wb_addr == bus.req_rs1);
    assign w_byp2_addr = bus.wb_valid && (bus.wb_addr == bus.req_rs2);

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign w_op1[i*DATA_W +: DATA_W] =
                (w_byp1_addr && bus.wb_mask[i])      ? bus.wb_data[i*DATA_W +: DATA_W] :
                (bus.req_mask[i] && bus.req_use1)    ? bus.rdata_0[i*DATA_W +: DATA_W] :
                                                       '0;
            assign w_op2[i*DATA_W +: DATA_W] =
                (w_byp2_addr && bus.wb_mask[i])      ? bus.wb_data[i*DATA_W +: DATA_W] :
                (bus.req_mask[i] && bus.req_use2)    ? bus.rdata_1[i*DATA_W +: DATA_W] :
                                                       '0;
        end
    endgenerate

    // Clear first so a new destination claim on the same register wins
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_wb_clr) begin
            w_pending_nxt[bus.wb_addr] = 1'b0;
        end
        if (w_accept && bus.req_wr) begin
            w_pending_nxt[bus.req_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_op1   <= '0;
            r_out_op2   <= '0;
            r_out_mask  <= '0;
            r_out_tag   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_op1   <= w_op1;
            r_out_op2   <= w_op2;
            r_out_mask  <= bus.req_mask;
            r_out_tag   <= bus.req_tag;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_op1   = r_out_op1;
    assign bus.out_op2   = r_out_op2;
    assign bus.out_mask  = r_out_mask;
    assign bus.out_tag   = r_out_tag;
endmodule
`default_nettype wire

// File: doc/rb_operand_fetch.md
Name: rb_operand_fetch

Overview:
- Requester-side controller for register_bank: drives the bank's two read ports and single write port on behalf of the pipeline.
- Accepts decoded-instruction operand requests (valid/ready), reads rs1/rs2 for all enabled lanes and registers the operands toward execute (valid/ready).
- Commits writeback data to the bank.
- Keeps a per-register pending scoreboard and bypasses same-cycle writeback into fetched operands.

Parameters:
LANES, 16, SIMD lanes (bit width of every lane mask)
DATA_W, 64, bits per lane register
ADDR_W, 6, register address width (2**ADDR_W registers)
TAG_W, 8, opaque instruction tag carried request->output

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset; asynchronous, active-high
req_valid  in  1  operand request valid
req_ready  out  1  request accepted when req_valid&&req_ready at rising edge
req_rs1  in  ADDR_W  source 1 address
req_rs2  in  ADDR_W  source 2 address
req_use1  in  1  rs1 needed
req_use2  in  1  rs2 needed
req_rd  in  ADDR_W  destination address
req_wr  in  1  instruction writes rd (marks rd pending)
req_mask  in  LANES  active lanes
req_tag  in  TAG_W  tag
out_valid  out  1  operands valid
out_ready  in  1  execute accepts
out_op1  out  LANES*DATA_W  rs1 operands, lane i at [i*DATA_W +: DATA_W]
out_op2  out  LANES*DATA_W  rs2 operands, same packing
out_mask  out  LANES  registered req_mask
out_tag  out  TAG_W  registered req_tag
wb_valid  in  1  writeback this cycle (always accepted, no stall)
wb_addr  in  ADDR_W  writeback register
wb_mask  in  LANES  lanes written
wb_data  in  LANES*DATA_W  writeback data, same packing
wb_last  in  1  final writeback for wb_addr; clears its pending bit
read_en_0, read_en_1  out  LANES  to bank read ports
raddr_0, raddr_1  out  ADDR_W  to bank read ports
rdata_0, rdata_1  in  LANES*DATA_W  from bank (flattened rdata_p_lane)
write_en  out  LANES  to bank write port
waddr  out  ADDR_W  to bank write port
wdata  out  LANES*DATA_W  to bank write port

Behaviour:
- Bank read is combinational from raddr/read_en; bank write commits at the rising edge with write_en.
- Read ports (combinational):
  - raddr_0 = req_rs1; read_en_0 = req_mask when req_valid&&req_use1, else 0.
  - raddr_1 = req_rs2; read_en_1 = req_mask when req_valid&&req_use2, else 0.
- Write port (combinational): write_en = wb_valid ? wb_mask : 0; waddr = wb_addr; wdata = wb_data.
- Scoreboard: pending[2**ADDR_W], reset all 0.
- Hazard: hz = (req_use1 && pending[rs1] && !(wb_valid&&wb_last&&wb_addr==rs1)) || the same term for rs2.
- req_ready = !hz && (!out_valid || out_ready). Single output stage, full-throughput pass-through when out_ready=1.
- On accept, register into the output stage:
  - out_op1 lane i = wb_data lane i if wb_valid && wb_addr==rs1 && wb_mask[i]; else rdata_0 lane i if req_mask[i]&&req_use1; else 0.
  - out_op2 is the same using rs2/rdata_1.
  - out_mask, out_tag.
  - out_valid <= 1.
- No accept and out_ready=1: out_valid <= 0; data regs hold value.
- Pending update each edge:
  - clear pending[wb_addr] if wb_valid&&wb_last.
  - then set pending[req_rd] if accept&&req_wr. Set wins on same address.
- rs1==rs2 is legal; both ports read the same address.
- rd equal to rs1/rs2 is legal; the source is read before rd is marked pending.
- wb_valid with wb_last=0 writes the bank and bypasses but leaves pending set.
- Reset (any time, including mid-transfer) forces immediately:
  - out_valid=0, out_op1/out_op2/out_mask/out_tag=0, pending all 0.
  - Combinational outputs follow inputs. read_en/write_en are 0 when req_valid/wb_valid are 0.
  - req_ready is 1 during reset.
- out_* must be stable while out_valid&&!out_ready.

Test Plan:
1. Reset then idle.
   - Stimulus: rst=1 for 2 cycles, all valids 0.
   - Required: out_valid=0, outputs 0, read_en_*/write_en=0, req_ready=1.
2. Write then fetch.
   - Stimulus: wb to r5, mask FFFF, lane i = 64'hA5A5_0000_0000_0000+i, wb_last=1. Next cycle, request rs1=r5 rs2=r5 mask FFFF.
   - Required: one cycle later out_valid=1, both operands lane i = A5A5_..._i. Reading r5 again gives the same values.
3. Partial mask.
   - Stimulus: request with req_mask=16'h00F0.
   - Required: only lanes 4-7 of out_op1/out_op2 are nonzero; read_en_0=16'h00F0.
4. Scoreboard stall and release.
   - Stimulus: accept req_wr rd=r9. Next request rs1=r9.
   - Required: req_ready=0 until wb_valid&&wb_last to r9. In that same cycle req_ready=1 and out_op1 takes wb_data in masked lanes.
5. Backpressure.
   - Stimulus: out_ready=0 with out_valid=1, then 3 new requests.
   - Required: req_ready=0 and out_* held constant. After out_ready=1, back-to-back transfers occur one per cycle with tags 1,2,3 in order.
6. Reset mid-operation.
   - Stimulus: assert rst while out_valid=1 and pending[r9]=1.
   - Required: out_valid=0 immediately. After release, a request with rs1=r9 is accepted without a stall.
